mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between instruction fetch (IF) and load/store (LS).
- Accepts one request at a time from either side and drives it onto the memory bus with a valid/ready handshake.
- Waits for the memory response and returns it, registered, to the owning requester.
- Sits between the fetch/LSU logic and the memory model. `busy` tells the PC logic to hold.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_arb_pick.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared encodings for the memory port arbiter: FSM state, transaction owner,
//   the 64-bit register-bus width, and a helper that picks the 32-bit
//   instruction half out of a 64-bit memory beat.
package mem_port_arbiter_pkg;

  // Width of the core's 64-bit register/memory buses.
  localparam int REG_BUS_W = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } arb_owner_t;

  // half = 1 selects the upper word (PC bit 2 set), else the lower word.
  function automatic logic [31:0] select_inst(input logic [REG_BUS_W-1:0] line,
                                              input logic                 half);
    return half ? line[63:32] : line[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick
//   Combinational grant selection between instruction fetch and load/store.
//   Build option: define ARB_RR_EN for round-robin on contention (the side not
//   granted last wins); otherwise load/store has fixed priority over fetch.
//   Ports:
//     i_if_valid, i_ls_valid : pending requests
//     i_last_owner           : owner of the previous grant (round-robin only)
//     o_grant_if, o_grant_ls : one-hot (or zero) grant
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       i_if_valid,
  input  logic       i_ls_valid,
  input  arb_owner_t i_last_owner,
  output logic       o_grant_if,
  output logic       o_grant_ls
);

`ifdef ARB_RR_EN
  always_comb begin
    o_grant_if = 1'b0;
    o_grant_ls = 1'b0;
    if (i_if_valid && i_ls_valid) begin
      if (i_last_owner == OWN_IF) o_grant_ls = 1'b1;
      else                        o_grant_if = 1'b1;
    end else begin
      o_grant_if = i_if_valid;
      o_grant_ls = i_ls_valid;
    end
  end
`else
  // Fixed priority never looks at history.
  logic w_unused_last_owner;
  assign w_unused_last_owner = i_last_owner;

  assign o_grant_ls = i_ls_valid;
  assign o_grant_if = i_if_valid & ~i_ls_valid;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single memory port between instruction fetch (IF) and
//   load/store (LS). One transaction outstanding at a time; the response is
//   returned registered to the owner as a one-cycle pulse.
//   Build option: ARB_RR_EN selects round-robin arbitration (see arb_pick).
//
//   state    | meaning
//   ---------+--------------------------------------------------------
//   ARB_IDLE | free; grant a requester and latch its request
//   ARB_REQ  | mem_req_valid high with latched fields until mem_req_ready
//   ARB_RESP | waiting for mem_rsp_valid; response registered on arrival
//
//   Ports:
//     clk, rst                  : clock, synchronous active-high reset
//     i_if_req_* / o_if_req_ready, o_if_rsp_* : fetch request/response
//     i_ls_req_* / o_ls_req_ready, o_ls_rsp_* : load/store request/response
//     o_mem_req_* / i_mem_req_ready           : memory bus request
//     i_mem_rsp_valid, i_mem_rsp_rdata        : memory bus response
//     o_busy                                  : transaction outstanding
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_if_req_valid,
  input  logic [ADDR_W-1:0] i_if_req_addr,
  output logic              o_if_req_ready,
  output logic              o_if_rsp_valid,
  output logic [INST_W-1:0] o_if_rsp_inst,

  input  logic              i_ls_req_valid,
  input  logic              i_ls_req_we,
  input  logic [ADDR_W-1:0] i_ls_req_addr,
  input  logic [DATA_W-1:0] i_ls_req_wdata,
  input  logic [7:0]        i_ls_req_wmask,
  output logic              o_ls_req_ready,
  output logic              o_ls_rsp_valid,
  output logic [DATA_W-1:0] o_ls_rsp_rdata,

  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_req_we,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  output logic [DATA_W-1:0] o_mem_req_wdata,
  output logic [7:0]        o_mem_req_wmask,
  input  logic              i_mem_rsp_valid,
  input  logic [DATA_W-1:0] i_mem_rsp_rdata,

  output logic              o_busy
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  arb_owner_t        r_owner;
  arb_owner_t        r_last_owner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [7:0]        r_wmask;
  logic              r_half;
  logic              r_if_rsp_valid;
  logic              r_ls_rsp_valid;
  logic [INST_W-1:0] r_if_rsp_inst;
  logic [DATA_W-1:0] r_ls_rsp_rdata;

  logic              w_grant_if;
  logic              w_grant_ls;
  logic              w_accept;
  logic              w_rsp_done;
  logic [1:0]        w_unused_if_addr_lo;

  // Fetches are always full aligned beats; the byte offset within a word is
  // meaningless to the bus.
  assign w_unused_if_addr_lo = i_if_req_addr[1:0];

  arb_pick u_arb_pick (
    .i_if_valid   (i_if_req_valid),
    .i_ls_valid   (i_ls_req_valid),
    .i_last_owner (r_last_owner),
    .o_grant_if   (w_grant_if),
    .o_grant_ls   (w_grant_ls)
  );

  assign w_accept   = (r_state == ARB_IDLE) & (w_grant_if | w_grant_ls);
  assign w_rsp_done = (r_state == ARB_RESP) & i_mem_rsp_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: if (w_grant_if | w_grant_ls) w_state_nxt = ARB_REQ;
      ARB_REQ:  if (i_mem_req_ready)         w_state_nxt = ARB_RESP;
      ARB_RESP: if (i_mem_rsp_valid)         w_state_nxt = ARB_IDLE;
      default:                               w_state_nxt = ARB_IDLE;
    endcase
  end

  // Outputs; ready is masked during reset so nothing is accepted then.
  always_comb begin
    o_if_req_ready  = 1'b0;
    o_ls_req_ready  = 1'b0;
    o_mem_req_valid = 1'b0;
    o_busy          = 1'b1;
    case (r_state)
      ARB_IDLE: begin
        o_if_req_ready = w_grant_if & ~rst;
        o_ls_req_ready = w_grant_ls & ~rst;
        o_busy         = 1'b0;
      end
      ARB_REQ:  o_mem_req_valid = 1'b1;
      default:  ;
    endcase
  end

  // Request latch: the requester may drop or change its inputs after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_half  <= 1'b0;
    end else if (w_accept) begin
      if (w_grant_ls) begin
        r_owner <= OWN_LS;
        r_we    <= i_ls_req_we;
        r_addr  <= i_ls_req_addr;
        r_wdata <= i_ls_req_wdata;
        r_wmask <= i_ls_req_wmask;
        r_half  <= 1'b0;
      end else begin
        r_owner <= OWN_IF;
        r_we    <= 1'b0;
        r_addr  <= {i_if_req_addr[ADDR_W-1:3], 3'b000};
        r_wdata <= '0;
        r_wmask <= 8'hFF;
        r_half  <= i_if_req_addr[2];
      end
    end
  end

  // Grant history; only arb_pick's round-robin build reads it, so the
  // fixed-priority build trims it away.
  always_ff @(posedge clk) begin
    if (rst)           r_last_owner <= OWN_IF;
    else if (w_accept) r_last_owner <= w_grant_ls ? OWN_LS : OWN_IF;
  end

  // Response registers; data holds until the next response for that owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rsp_valid <= 1'b0;
      r_ls_rsp_valid <= 1'b0;
      r_if_rsp_inst  <= '0;
      r_ls_rsp_rdata <= '0;
    end else begin
      r_if_rsp_valid <= w_rsp_done & (r_owner == OWN_IF);
      r_ls_rsp_valid <= w_rsp_done & (r_owner == OWN_LS);
      if (w_rsp_done && r_owner == OWN_IF)
        r_if_rsp_inst <= select_inst(i_mem_rsp_rdata, r_half);
      if (w_rsp_done && r_owner == OWN_LS)
        r_ls_rsp_rdata <= i_mem_rsp_rdata;
    end
  end

  assign o_mem_req_we    = r_we;
  assign o_mem_req_addr  = r_addr;
  assign o_mem_req_wdata = r_wdata;
  assign o_mem_req_wmask = r_wmask;
  assign o_if_rsp_valid  = r_if_rsp_valid;
  assign o_if_rsp_inst   = r_if_rsp_inst;
  assign o_ls_rsp_valid  = r_ls_rsp_valid;
  assign o_ls_rsp_rdata  = r_ls_rsp_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_if_req_valid;
  logic [63:0] i_if_req_addr;
  logic        o_if_req_ready, o_if_rsp_valid;
  logic [31:0] o_if_rsp_inst;
  logic        i_ls_req_valid, i_ls_req_we;
  logic [63:0] i_ls_req_addr, i_ls_req_wdata;
  logic [7:0]  i_ls_req_wmask;
  logic        o_ls_req_ready, o_ls_rsp_valid;
  logic [63:0] o_ls_rsp_rdata;
  logic        o_mem_req_valid, i_mem_req_ready, o_mem_req_we;
  logic [63:0] o_mem_req_addr, o_mem_req_wdata;
  logic [7:0]  o_mem_req_wmask;
  logic        i_mem_rsp_valid;
  logic [63:0] i_mem_rsp_rdata;
  logic        o_busy;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_if_req_valid(i_if_req_valid), .i_if_req_addr(i_if_req_addr),
    .o_if_req_ready(o_if_req_ready), .o_if_rsp_valid(o_if_rsp_valid),
    .o_if_rsp_inst(o_if_rsp_inst),
    .i_ls_req_valid(i_ls_req_valid), .i_ls_req_we(i_ls_req_we),
    .i_ls_req_addr(i_ls_req_addr), .i_ls_req_wdata(i_ls_req_wdata),
    .i_ls_req_wmask(i_ls_req_wmask), .o_ls_req_ready(o_ls_req_ready),
    .o_ls_rsp_valid(o_ls_rsp_valid), .o_ls_rsp_rdata(o_ls_rsp_rdata),
    .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
    .o_mem_req_we(o_mem_req_we), .o_mem_req_addr(o_mem_req_addr),
    .o_mem_req_wdata(o_mem_req_wdata), .o_mem_req_wmask(o_mem_req_wmask),
    .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rsp_rdata(i_mem_rsp_rdata),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    logic [63:0] data;
    int          due;
  } txn_t;

  txn_t rsp_q[$];
  txn_t cur;
  int   checks = 0;
  int   errors = 0;

  // requester intent
  bit          req_if_v = 0;
  logic [63:0] req_if_a = '0;
  bit          req_ls_v = 0, req_ls_we = 0;
  logic [63:0] req_ls_a = '0, req_ls_wd = '0;
  logic [7:0]  req_ls_wm = '0;

  // reference model of the port: is a transaction outstanding, and has the
  // memory accepted its request yet
  bit m_has = 0, m_issued = 0, post_rst = 0;
`ifdef ARB_RR_EN
  bit last_ls = 0;
`endif
  int wait_cnt = 0, rsp_cnt = 0;

  // memory/test knobs
  bit          rand_delays = 0, spur_en = 0, force_rsp = 0, fixed_en = 0, gap_check = 0;
  int          ready_delay = 0, rsp_delay = 0, prev_grant = -1, n_if_grants = 0;
  logic [63:0] fixed_val = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mem_val(input logic [63:0] a);
    if (fixed_en) return fixed_val;
    return {a[31:0] ^ 32'h5A5A_0F0F, a[63:32] + a[31:0]};
  endfunction

  // Response monitor: pops the scoreboard whenever the DUT presents a pulse.
  always @(negedge clk) begin
    txn_t t;
    if (o_if_rsp_valid || o_ls_rsp_valid) begin
      if (rsp_q.size() == 0) begin
        chk("rsp_unexpected", 64'({o_if_rsp_valid, o_ls_rsp_valid}), 64'd0);
      end else begin
        t = rsp_q.pop_front();
        chk("rsp_cycle", 64'(cyc), 64'(t.due));
        chk("rsp_if_valid", 64'(o_if_rsp_valid), 64'(!t.is_ls));
        chk("rsp_ls_valid", 64'(o_ls_rsp_valid), 64'(t.is_ls));
        if (!t.is_ls)    chk("if_rsp_inst", 64'(o_if_rsp_inst), 64'(t.data[31:0]));
        else if (!t.we)  chk("ls_rsp_rdata", o_ls_rsp_rdata, t.data);
      end
    end else if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      chk("rsp_missing", 64'd0, 64'd1);
      void'(rsp_q.pop_front());
    end
  end

  // One clock cycle: drive requesters and memory, compare, advance the model.
  task automatic tick(input bit do_rst);
    bit          gi, gl, mem_rdy, mem_rv;
    logic [63:0] rdata, line, sh;
    @(negedge clk);
    #1;
    if (post_rst) begin
      chk("rst_if_rsp_valid", 64'(o_if_rsp_valid), 64'd0);
      chk("rst_ls_rsp_valid", 64'(o_ls_rsp_valid), 64'd0);
      chk("rst_if_rsp_inst", 64'(o_if_rsp_inst), 64'd0);
      chk("rst_ls_rsp_rdata", o_ls_rsp_rdata, 64'd0);
      chk("rst_mem_addr", o_mem_req_addr, 64'd0);
      chk("rst_mem_wdata", o_mem_req_wdata, 64'd0);
      chk("rst_mem_wmask_we", 64'({o_mem_req_wmask, o_mem_req_we}), 64'd0);
      post_rst = 0;
    end
    rst            = do_rst;
    i_if_req_valid = req_if_v;
    i_if_req_addr  = req_if_a;
    i_ls_req_valid = req_ls_v;
    i_ls_req_we    = req_ls_we;
    i_ls_req_addr  = req_ls_a;
    i_ls_req_wdata = req_ls_wd;
    i_ls_req_wmask = req_ls_wm;
    mem_rdy = 0;
    mem_rv  = 0;
    rdata   = {$urandom, $urandom};
    if (m_has && !m_issued) begin
      if (wait_cnt == 0) mem_rdy = 1;
      else wait_cnt--;
      mem_rv = spur_en && ($urandom_range(0, 2) == 0);
    end else if (m_has) begin
      if (rsp_cnt == 0) begin
        mem_rv = 1;
        rdata  = mem_val(cur.addr);
      end else rsp_cnt--;
    end else begin
      mem_rv = spur_en && ($urandom_range(0, 2) == 0);
    end
    if (force_rsp) mem_rv = 1;
    i_mem_req_ready = (m_has && !m_issued) ? mem_rdy
                    : (spur_en ? 1'($urandom_range(0, 1)) : 1'b0);
    i_mem_rsp_valid = mem_rv;
    i_mem_rsp_rdata = rdata;
    #1;
    gi = 0;
    gl = 0;
    if (!do_rst && !m_has) begin
      if (req_ls_v && req_if_v) begin
`ifdef ARB_RR_EN
        if (last_ls) gi = 1; else gl = 1;
`else
        gl = 1;
`endif
      end else if (req_ls_v) gl = 1;
      else if (req_if_v) gi = 1;
    end
    chk("if_req_ready", 64'(o_if_req_ready), 64'(gi));
    chk("ls_req_ready", 64'(o_ls_req_ready), 64'(gl));
    chk("busy", 64'(o_busy), 64'(m_has));
    chk("mem_req_valid", 64'(o_mem_req_valid), 64'(m_has && !m_issued));
    if (m_has && !m_issued) begin
      chk("mem_req_addr", o_mem_req_addr, cur.addr);
      chk("mem_req_we", 64'(o_mem_req_we), 64'(cur.we));
      chk("mem_req_wmask", 64'(o_mem_req_wmask), 64'(cur.wmask));
      if (cur.is_ls) chk("mem_req_wdata", o_mem_req_wdata, cur.wdata);
    end
    if (do_rst) begin
      m_has    = 0;
      m_issued = 0;
`ifdef ARB_RR_EN
      last_ls  = 0;
`endif
      rsp_q.delete();
      post_rst = 1;
    end else if (gi || gl) begin
      if (gl) begin
        cur.is_ls = 1; cur.we = req_ls_we; cur.addr = req_ls_a;
        cur.wdata = req_ls_wd; cur.wmask = req_ls_wm;
        cur.data  = mem_val(req_ls_a);
        req_ls_v  = 0;
      end else begin
        cur.is_ls = 0; cur.we = 0; cur.addr = {req_if_a[63:3], 3'b000};
        cur.wdata = '0; cur.wmask = 8'hFF;
        line      = mem_val(cur.addr);
        sh        = line >> (req_if_a[2] ? 32 : 0);
        cur.data  = {32'd0, sh[31:0]};
        req_if_v  = 0;
        n_if_grants++;
        if (gap_check && prev_grant >= 0) chk("grant_gap", 64'(cyc - prev_grant), 64'd3);
        prev_grant = cyc;
      end
      cur.due = -1;
      rsp_q.push_back(cur);
      m_has    = 1;
      m_issued = 0;
`ifdef ARB_RR_EN
      last_ls  = gl;
`endif
      wait_cnt = rand_delays ? $urandom_range(0, 3) : ready_delay;
      rsp_cnt  = rand_delays ? $urandom_range(0, 3) : rsp_delay;
    end else if (m_has && !m_issued && mem_rdy) begin
      m_issued = 1;
    end else if (m_has && m_issued && mem_rv) begin
      m_has    = 0;
      m_issued = 0;
      if (rsp_q.size() > 0) rsp_q[rsp_q.size()-1].due = cyc + 1;
    end
  endtask

  initial begin
    rst = 1; i_if_req_valid = 0; i_if_req_addr = '0; i_ls_req_valid = 0;
    i_ls_req_we = 0; i_ls_req_addr = '0; i_ls_req_wdata = '0; i_ls_req_wmask = '0;
    i_mem_req_ready = 0; i_mem_rsp_valid = 0; i_mem_rsp_rdata = '0;
    tick(1); tick(1);
    tick(0);

    // IF at 0x1004, instant memory, upper word expected
    fixed_en = 1; fixed_val = 64'hAAAA_BBBB_CCCC_DDDD;
    req_if_v = 1; req_if_a = 64'h1004;
    repeat (5) tick(0);
    fixed_en = 0;

    // contention: LS load vs IF, LS re-requests right after its grant
    req_ls_v = 1; req_ls_we = 0; req_ls_a = 64'h2000;
    req_if_v = 1; req_if_a = 64'h1000;
    tick(0);
    req_ls_v = 1; req_ls_we = 0; req_ls_a = 64'h2008;
    repeat (10) tick(0);

    // store with 3 stalled cycles of mem_req_ready
    ready_delay = 3;
    req_ls_v = 1; req_ls_we = 1; req_ls_a = 64'h3008;
    req_ls_wd = 64'h1122_3344_5566_7788; req_ls_wm = 8'h0F;
    repeat (8) tick(0);

    // spurious responses in IDLE and REQ
    spur_en = 1; rsp_delay = 2;
    repeat (3) tick(0);
    req_if_v = 1; req_if_a = 64'h7000;
    repeat (10) tick(0);
    spur_en = 0; ready_delay = 0; rsp_delay = 0;
    force_rsp = 1; tick(0); force_rsp = 0;

    // reset while waiting in RESP, late response must be dropped
    rsp_delay = 4;
    req_if_v = 1; req_if_a = 64'h5000;
    for (int n = 0; n < 10 && !m_issued; n++) tick(0);
    tick(0);
    tick(1);
    force_rsp = 1; tick(0); force_rsp = 0;
    rsp_delay = 0;
    req_if_v = 1; req_if_a = 64'h6004;
    repeat (6) tick(0);

    // continuous fetch stream with instant memory
    gap_check = 1; prev_grant = -1; n_if_grants = 0;
    for (int n = 0; n < 100 && n_if_grants < 20; n++) begin
      if (!req_if_v) begin req_if_v = 1; req_if_a = 64'h4000 + 64'(n * 4); end
      tick(0);
    end
    req_if_v = 0; gap_check = 0;
    chk("fetch_count", 64'(n_if_grants), 64'd20);
    repeat (5) tick(0);

    // randomized traffic
    rand_delays = 1; spur_en = 1;
    for (int n = 0; n < 1500; n++) begin
      if (!req_if_v && $urandom_range(0, 2) == 0) begin
        req_if_v = 1; req_if_a = {$urandom, $urandom};
      end
      if (!req_ls_v && $urandom_range(0, 3) == 0) begin
        req_ls_v = 1; req_ls_we = 1'($urandom_range(0, 1));
        req_ls_a = {$urandom, $urandom}; req_ls_wd = {$urandom, $urandom};
        req_ls_wm = 8'($urandom);
      end
      tick($urandom_range(0, 199) == 0);
    end
    req_if_v = 0; req_ls_v = 0; spur_en = 0; rand_delays = 0;
    repeat (20) tick(0);
    chk("rsp_drain", 64'(rsp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
